// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver: synchronise, filter, deframe, then fold E0/F0/E1 prefixes into an 11-bit key event.
// Define PS2KEY_PARITY_EN to reject frames whose odd parity check fails.
module ps2_key_encoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 25000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic [1:0]    clkSync_q, dataSync_q;
  logic          fclk_q, fclk_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          strobe_q, strobe_d;
  logic          dataBit_q;
  state_e        state_q, state_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          byteValid_q, byteValid_d;
  logic [7:0]    byteData_q, byteData_d;
  logic          frameErr_q, frameErr_d;
  logic          wdogExpire;
  logic          frameGood;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [2:0]    skip_q, skip_d;
  logic [10:0]   key_q, key_d;

`ifdef PS2KEY_PARITY_EN
  logic parity_q, parity_d;
  assign frameGood = dataBit_q & (^{shift_q, parity_q});
`else
  assign frameGood = dataBit_q;
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clkSync_q   <= 2'b11;
      dataSync_q  <= 2'b11;
      fclk_q      <= 1'b1;
      fcnt_q      <= '0;
      strobe_q    <= 1'b0;
      dataBit_q   <= 1'b1;
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      wdog_q      <= '0;
      byteValid_q <= 1'b0;
      byteData_q  <= '0;
      frameErr_q  <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      skip_q      <= '0;
      key_q       <= '0;
`ifdef PS2KEY_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      clkSync_q   <= {clkSync_q[0], ps2_clk_in};
      dataSync_q  <= {dataSync_q[0], ps2_data_in};
      fclk_q      <= fclk_d;
      fcnt_q      <= fcnt_d;
      strobe_q    <= strobe_d;
      dataBit_q   <= dataSync_q[1];
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      wdog_q      <= wdog_d;
      byteValid_q <= byteValid_d;
      byteData_q  <= byteData_d;
      frameErr_q  <= frameErr_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      skip_q      <= skip_d;
      key_q       <= key_d;
`ifdef PS2KEY_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  // Any disagreeing sample run shorter than FILTER_LEN restarts the count, so short glitches vanish.
  always_comb begin
    fclk_d = fclk_q;
    fcnt_d = '0;
    if (clkSync_q[1] != fclk_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        fclk_d = ~fclk_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    strobe_d = fclk_q & ~fclk_d;
  end

  // A strobe always beats a watchdog expiry landing on the same cycle.
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    wdog_d      = '0;
    byteValid_d = 1'b0;
    byteData_d  = byteData_q;
    frameErr_d  = 1'b0;
    wdogExpire  = 1'b0;
`ifdef PS2KEY_PARITY_EN
    parity_d    = parity_q;
`endif
    if (strobe_q) begin
      unique case (state_q)
        IDLE: begin
          if (!dataBit_q) begin
            state_d  = DATA;
            bitCnt_d = '0;
          end
        end
        DATA: begin
          shift_d  = {dataBit_q, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 1'b1;
          if (bitCnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
`ifdef PS2KEY_PARITY_EN
          parity_d = dataBit_q;
`endif
          state_d = STOP;
        end
        STOP: begin
          if (frameGood) begin
            byteValid_d = 1'b1;
            byteData_d  = shift_q;
          end else begin
            frameErr_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (wdog_q == WW'(TIMEOUT_CYC - 1)) begin
        wdogExpire = 1'b1;
        frameErr_d = 1'b1;
        state_d    = IDLE;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
  end

  // Controller responses and the Pause sequence never reach the key word.
  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    skip_d = skip_q;
    key_d  = key_q;
    if (wdogExpire) begin
      ext_d  = 1'b0;
      brk_d  = 1'b0;
      skip_d = '0;
    end else if (byteValid_q) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 1'b1;
      end else begin
        unique case (byteData_q)
          8'hE0: ext_d  = 1'b1;
          8'hF0: brk_d  = 1'b1;
          8'hE1: skip_d = 3'd7;
          8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
          default: begin
            key_d = {~key_q[10], ~brk_q, ext_q, byteData_q};
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        endcase
      end
    end
  end

  assign ps2_key    = key_q;
  assign byte_valid = byteValid_q;
  assign byte_data  = byteData_q;
  assign frame_err  = frameErr_q;

endmodule
